// File: rtl/sdes_round_sequencer.sv
// Iterative S-DES controller: one Fk datapath shared by both rounds, with key schedule,
// round sequencing and a valid/ready result port with backpressure.
module sdes_round_sequencer #(
   parameter int FK_LATENCY  = 1,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   inValid,
   output logic                   inReady,
   input  logic [7:0]             inData,
   input  logic [9:0]             inKey,
   input  logic                   inMode,
   output logic                   outValid,
   input  logic                   outReady,
   output logic [7:0]             outData,
   output logic                   busy,
   output logic [COUNT_WIDTH-1:0] opCount
);

   typedef enum logic [2:0] {IDLE, KEY, R1, R2, OUT} seqState_t;

   localparam logic [3:0] WAIT_LAST = 4'(FK_LATENCY - 1);

   // S-box contents, entry {row,col} at bit 2*idx; row = outer bits, col = inner bits
   localparam logic [31:0] S0_TBL = {2'd2, 2'd3, 2'd1, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0,
                                     2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd1};
   localparam logic [31:0] S1_TBL = {2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3,
                                     2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};

   seqState_t                state, nextState;
   logic [7:0]               blockReg;
   logic [9:0]               keyReg;
   logic                     modeReg;
   logic [7:0]               subKey1, subKey2;
   logic [3:0]               waitCnt;
   logic [7:0]               outDataReg;
   logic [COUNT_WIDTH-1:0]   opCountReg;

   // Bit positions below use S-DES numbering: position 1 is the leftmost (MSB) bit
   function automatic logic [9:0] perm10(input logic [9:0] k);
      return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
   endfunction

   function automatic logic [7:0] perm8(input logic [9:0] k);
      return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
   endfunction

   function automatic logic [7:0] initPerm(input logic [7:0] d);
      return {d[6], d[2], d[5], d[7], d[4], d[0], d[3], d[1]};
   endfunction

   function automatic logic [7:0] invPerm(input logic [7:0] d);
      return {d[4], d[7], d[5], d[3], d[1], d[6], d[0], d[2]};
   endfunction

   function automatic logic [7:0] expandPerm(input logic [3:0] r);
      return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
   endfunction

   function automatic logic [3:0] perm4(input logic [3:0] v);
      return {v[2], v[0], v[1], v[3]};
   endfunction

   function automatic logic [1:0] sBox(input logic [31:0] tbl, input logic [3:0] x);
      logic [3:0] idx;
      idx = {x[3], x[0], x[2], x[1]};
      return tbl[{idx, 1'b0} +: 2];
   endfunction

   // Key schedule, combinational from the registered key
   logic [9:0] p10Key, ls1Key, ls2Key;
   assign p10Key = perm10(keyReg);
   assign ls1Key = {p10Key[8:5], p10Key[9], p10Key[3:0], p10Key[4]};
   assign ls2Key = {ls1Key[7:5], ls1Key[9:8], ls1Key[2:0], ls1Key[4:3]};

   // Shared Fk datapath; decrypt swaps the order the subkeys are applied
   logic [7:0] roundKey, epXor, fkOut;
   logic [3:0] sOut;
   logic       fkLast, accept;

   always_comb begin
      roundKey = ((state == R1) ^ modeReg) ? subKey1 : subKey2;
      epXor    = expandPerm(blockReg[3:0]) ^ roundKey;
      sOut     = perm4({sBox(S0_TBL, epXor[7:4]), sBox(S1_TBL, epXor[3:0])});
      fkOut    = {blockReg[7:4] ^ sOut, blockReg[3:0]};
   end

   assign fkLast = (waitCnt == WAIT_LAST);
   assign accept = inValid && (state == IDLE);

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (accept) nextState = KEY;
         KEY:     nextState = R1;
         R1:      if (fkLast) nextState = R2;
         R2:      if (fkLast) nextState = OUT;
         OUT:     if (outReady) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nextState;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blockReg   <= '0;
         keyReg     <= '0;
         modeReg    <= 1'b0;
         subKey1    <= '0;
         subKey2    <= '0;
         waitCnt    <= '0;
         outDataReg <= '0;
         opCountReg <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               blockReg <= initPerm(inData);
               keyReg   <= inKey;
               modeReg  <= inMode;
            end
            KEY: begin
               subKey1 <= perm8(ls1Key);
               subKey2 <= perm8(ls2Key);
            end
            R1: if (fkLast) blockReg <= {fkOut[3:0], fkOut[7:4]};
            R2: if (fkLast) begin
               blockReg   <= fkOut;
               outDataReg <= invPerm(fkOut);
            end
            OUT: if (outReady) opCountReg <= opCountReg + 1'b1;
            default: ;
         endcase
         if ((state == R1 || state == R2) && !fkLast) waitCnt <= waitCnt + 4'd1;
         else                                         waitCnt <= '0;
      end
   end

   assign inReady  = (state == IDLE);
   assign busy     = (state != IDLE);
   assign outValid = (state == OUT);
   assign outData  = outDataReg;
   assign opCount  = opCountReg;

endmodule

// File: tb/tb_sdes_round_sequencer.sv
// Bench for sdes_round_sequencer: table-driven S-DES reference, expected results queued
// when a block is issued and compared when the result handshake appears.
module tb_sdes_round_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // default-parameter instance
   logic        inValid = 0, inMode = 0, outReady = 1;
   logic [7:0]  inData = 0;
   logic [9:0]  inKey = 0;
   logic        inReady, outValid, busy;
   logic [7:0]  outData;
   logic [15:0] opCount;

   // FK_LATENCY=4, COUNT_WIDTH=2 instance
   logic        inValid2 = 0, inMode2 = 0, outReady2 = 1;
   logic [7:0]  inData2 = 0;
   logic [9:0]  inKey2 = 0;
   logic        inReady2, outValid2, busy2;
   logic [7:0]  outData2;
   logic [1:0]  opCount2;

   sdes_round_sequencer dut (
      .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady), .inData(inData),
      .inKey(inKey), .inMode(inMode), .outValid(outValid), .outReady(outReady),
      .outData(outData), .busy(busy), .opCount(opCount));

   sdes_round_sequencer #(.FK_LATENCY(4), .COUNT_WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .inValid(inValid2), .inReady(inReady2), .inData(inData2),
      .inKey(inKey2), .inMode(inMode2), .outValid(outValid2), .outReady(outReady2),
      .outData(outData2), .busy(busy2), .opCount(opCount2));

   int errors = 0;
   int checks = 0;
   logic [7:0] expQ[$];
   logic [7:0] expQ2[$];

   // ---------------- reference model ----------------
   localparam int P10T[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
   localparam int P8T[10]  = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
   localparam int IPT[10]  = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
   localparam int IPIT[10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
   localparam int EPT[10]  = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
   localparam int P4T[10]  = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
   localparam int S0T[16]  = '{1, 0, 3, 2, 3, 2, 1, 0, 0, 2, 1, 3, 3, 1, 3, 2};
   localparam int S1T[16]  = '{0, 1, 2, 3, 2, 0, 1, 3, 3, 0, 1, 0, 2, 1, 0, 3};

   // position p (1 = leftmost) of an nIn-bit value sits at bit nIn-p
   function automatic logic [9:0] permute(input logic [9:0] v, input int nIn, input int nOut,
                                          input int tbl[10]);
      logic [9:0] o;
      o = '0;
      for (int i = 0; i < nOut; i++) o[nOut-1-i] = v[nIn-tbl[i]];
      return o;
   endfunction

   function automatic logic [4:0] rotl5(input logic [4:0] v, input int n);
      logic [4:0] r;
      r = v;
      for (int i = 0; i < n; i++) r = {r[3:0], r[4]};
      return r;
   endfunction

   function automatic void modelKeys(input logic [9:0] k, output logic [7:0] k1,
                                     output logic [7:0] k2);
      logic [9:0] p, t;
      p  = permute(k, 10, 10, P10T);
      t  = {rotl5(p[9:5], 1), rotl5(p[4:0], 1)};
      k1 = 8'(permute(t, 10, 8, P8T));
      t  = {rotl5(p[9:5], 3), rotl5(p[4:0], 3)};
      k2 = 8'(permute(t, 10, 8, P8T));
   endfunction

   function automatic logic [7:0] modelFk(input logic [7:0] s, input logic [7:0] sk);
      logic [7:0] x;
      logic [3:0] sv, p4;
      int r0, c0, r1, c1;
      x  = 8'(permute({6'b0, s[3:0]}, 4, 8, EPT)) ^ sk;
      r0 = {x[7], x[4]}; c0 = {x[6], x[5]};
      r1 = {x[3], x[0]}; c1 = {x[2], x[1]};
      sv = {2'(S0T[r0*4+c0]), 2'(S1T[r1*4+c1])};
      p4 = 4'(permute({6'b0, sv}, 4, 4, P4T));
      return {s[7:4] ^ p4, s[3:0]};
   endfunction

   function automatic logic [7:0] modelSdes(input logic [7:0] d, input logic [9:0] k,
                                            input logic m);
      logic [7:0] k1, k2, s;
      modelKeys(k, k1, k2);
      s = 8'(permute({2'b0, d}, 8, 8, IPT));
      s = modelFk(s, m ? k2 : k1);
      s = {s[3:0], s[7:4]};
      s = modelFk(s, m ? k1 : k2);
      return 8'(permute({2'b0, s}, 8, 8, IPIT));
   endfunction

   // ---------------- transaction helpers ----------------
   task automatic startAccept(input logic [7:0] d, input logic [9:0] k, input logic m);
      inData = d; inKey = k; inMode = m; inValid = 1;
      @(posedge clk); #1;
      inValid = 0;
   endtask

   task automatic waitOut(input int startN, input int wantLat, input string tag);
      int n;
      logic [7:0] e;
      n = startN;
      while (outValid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      checks++;
      if (n !== wantLat) begin
         errors++; $display("FAIL %s_latency got %0d cycles want %0d", tag, n, wantLat);
      end
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checks++;
         if (outData !== e) begin
            errors++; $display("FAIL %s_data got %b want %b", tag, outData, e);
         end
      end
   endtask

   task automatic runTxn(input logic [7:0] d, input logic [9:0] k, input logic m,
                         input logic [7:0] exp, input string tag, output logic [7:0] res);
      expQ.push_back(exp);
      checks++;
      if (inReady !== 1'b1) begin errors++; $display("FAIL %s_inReady got %b want 1", tag, inReady); end
      outReady = 1;
      startAccept(d, k, m);
      waitOut(0, 3, tag);
      res = outData;
      @(posedge clk); #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #2;
      checks++;
      if ({inReady, outValid, busy, opCount, outData} !== {1'b1, 1'b0, 1'b0, 16'd0, 8'd0}) begin
         errors++;
         $display("FAIL reset_state got rdy=%b vld=%b busy=%b cnt=%0d data=%h want 1 0 0 0 00",
                  inReady, outValid, busy, opCount, outData);
      end
      checks++;
      if ({inReady2, outValid2, busy2, opCount2} !== {1'b1, 1'b0, 1'b0, 2'd0}) begin
         errors++; $display("FAIL reset_state2 got rdy=%b vld=%b busy=%b cnt=%0d want 1 0 0 0",
                            inReady2, outValid2, busy2, opCount2);
      end
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      checks++;
      if ({inReady, outValid, busy} !== 3'b100) begin
         errors++; $display("FAIL post_reset got rdy=%b vld=%b busy=%b want 1 0 0", inReady, outValid, busy);
      end
   endtask

   task automatic test_keygen();
      expQ.push_back(8'b00111000);
      outReady = 1;
      startAccept(8'b10010111, 10'b1010000010, 1'b0);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL key_busy got %b want 1", busy); end
      @(posedge clk); #1;
      checks++;
      if (dut.subKey1 !== 8'b10100100) begin
         errors++; $display("FAIL k1 got %b want 10100100", dut.subKey1);
      end
      checks++;
      if (dut.subKey2 !== 8'b01000011) begin
         errors++; $display("FAIL k2 got %b want 01000011", dut.subKey2);
      end
      waitOut(1, 3, "known_vector");
      @(posedge clk); #1;
   endtask

   task automatic test_encrypt_all();
      logic [15:0] base;
      logic [7:0]  r;
      base = opCount;
      for (int i = 0; i < 256; i++)
         runTxn(8'(i), 10'b1010000010, 1'b0, modelSdes(8'(i), 10'b1010000010, 1'b0), "enc_all", r);
      checks++;
      if (opCount !== base + 16'd256) begin
         errors++; $display("FAIL enc_all_count got %0d want %0d", opCount, base + 16'd256);
      end
   endtask

   task automatic test_round_trip();
      logic [9:0] k;
      logic [7:0] d, c, p;
      for (int i = 0; i < 5; i++) begin
         k = 10'($urandom_range(0, 1023));
         d = 8'($urandom_range(0, 255));
         runTxn(d, k, 1'b0, modelSdes(d, k, 1'b0), "rt_enc", c);
         runTxn(c, k, 1'b1, d, "rt_dec", p);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0]  held, e, d;
      logic [15:0] cnt0;
      d = 8'hA5;
      outReady = 0;
      expQ.push_back(modelSdes(d, 10'h2C7, 1'b0));
      startAccept(d, 10'h2C7, 1'b0);
      waitOut(0, 3, "bp");
      held = outData;
      cnt0 = opCount;
      for (int i = 0; i < 10; i++) begin
         inValid = (i % 2 == 0); inData = 8'($urandom_range(0, 255)); inKey = 10'h155;
         @(posedge clk); #1;
         checks++;
         if ({outValid, inReady, busy} !== 3'b101) begin
            errors++; $display("FAIL bp_flags cyc %0d got vld=%b rdy=%b busy=%b want 1 0 1",
                               i, outValid, inReady, busy);
         end
         checks++;
         if (outData !== held || opCount !== cnt0) begin
            errors++; $display("FAIL bp_hold cyc %0d got data=%h cnt=%0d want %h %0d",
                               i, outData, opCount, held, cnt0);
         end
      end
      inValid = 0;
      outReady = 1;
      #1;
      checks++;
      if (inReady !== 1'b0) begin errors++; $display("FAIL bp_release_inReady got %b want 0", inReady); end
      @(posedge clk); #1;
      checks++;
      if (outValid !== 1'b0 || opCount !== cnt0 + 16'd1) begin
         errors++; $display("FAIL bp_deliver got vld=%b cnt=%0d want 0 %0d", outValid, opCount, cnt0 + 16'd1);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (busy !== 1'b0 || outValid !== 1'b0 || opCount !== cnt0 + 16'd1) begin
            errors++; $display("FAIL bp_single got busy=%b vld=%b cnt=%0d want 0 0 %0d",
                               busy, outValid, opCount, cnt0 + 16'd1);
         end
      end
      e = 8'h00;
   endtask

   task automatic test_reset_mid();
      logic [7:0] r;
      outReady = 1;
      startAccept(8'h3C, 10'h0F1, 1'b0);
      @(posedge clk); #1;
      rst_n = 0;
      #1;
      checks++;
      if ({outValid, busy, inReady, opCount} !== {1'b0, 1'b0, 1'b1, 16'd0}) begin
         errors++; $display("FAIL mid_reset got vld=%b busy=%b rdy=%b cnt=%0d want 0 0 1 0",
                            outValid, busy, inReady, opCount);
      end
      @(posedge clk); #3;
      rst_n = 1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (outValid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset_abandon got vld=%b busy=%b want 0 0", outValid, busy);
         end
      end
      runTxn(8'h3C, 10'h0F1, 1'b0, modelSdes(8'h3C, 10'h0F1, 1'b0), "after_reset", r);
      checks++;
      if (opCount !== 16'd1) begin errors++; $display("FAIL after_reset_count got %0d want 1", opCount); end
   endtask

   task automatic test_latency_param();
      int n;
      logic [7:0] d, e;
      logic [9:0] k;
      outReady2 = 1;
      for (int j = 0; j < 5; j++) begin
         d = 8'($urandom_range(0, 255));
         k = 10'($urandom_range(0, 1023));
         expQ2.push_back(modelSdes(d, k, 1'(j % 2)));
         inData2 = d; inKey2 = k; inMode2 = 1'(j % 2); inValid2 = 1;
         @(posedge clk); #1;
         inValid2 = 0;
         n = 0;
         while (outValid2 !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
         checks++;
         if (n !== 9) begin errors++; $display("FAIL lat4_latency got %0d want 9", n); end
         e = expQ2.pop_front();
         checks++;
         if (outData2 !== e) begin errors++; $display("FAIL lat4_data got %b want %b", outData2, e); end
         @(posedge clk); #1;
         checks++;
         if (opCount2 !== 2'((j + 1) % 4)) begin
            errors++; $display("FAIL lat4_count got %0d want %0d", opCount2, (j + 1) % 4);
         end
      end
   endtask

   initial begin
      test_reset();
      test_keygen();
      test_encrypt_all();
      test_round_trip();
      test_backpressure();
      test_reset_mid();
      test_latency_param();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
